// File: rtl/text_console_writer_if.sv
// text_console_writer_if: byte-input handshake, character-RAM CPU port and cursor status.
interface text_console_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [7:0]  in_attr;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic        ram_oe;
    logic [15:0] ram_dataOut;
    logic [15:0] ram_dataIn;
    logic [7:0]  cursor_col;
    logic [6:0]  cursor_row;
    logic        busy;

    modport master (
        output in_valid, in_char, in_attr, ram_dataIn,
        input  in_ready, ram_addr, ram_we, ram_oe, ram_dataOut, cursor_col, cursor_row, busy
    );
    modport slave (
        input  in_valid, in_char, in_attr, ram_dataIn,
        output in_ready, ram_addr, ram_we, ram_oe, ram_dataOut, cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// text_console_writer: turns a character byte stream into character-RAM writes,
// tracking a cursor with CR/LF/BS/FF handling, line wrap, scroll and clear.
module text_console_writer #(
    parameter int         N_COL      = 240,
    parameter int         N_ROW      = 67,
    parameter logic [7:0] CLEAR_ATTR = 8'h07
) (
    input logic                   cpu_clk,
    input logic                   rst_n,
    text_console_writer_if.slave  bus
);
    typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_BLANK} state_t;

    localparam logic [15:0] W_COL     = 16'(N_COL);
    localparam logic [15:0] LAST_CELL = 16'(N_COL * N_ROW - 1);
    localparam logic [15:0] LAST_BASE = 16'((N_ROW - 1) * N_COL);
    localparam logic [15:0] BLANK     = {CLEAR_ATTR, 8'h20};
    localparam logic [7:0]  LAST_COL  = 8'(N_COL - 1);
    localparam logic [6:0]  LAST_ROW  = 7'(N_ROW - 1);

    state_t      r_state;
    logic [15:0] r_addr, r_data, r_base;
    logic        r_we, r_oe, r_copy, r_ready, r_busy, r_scroll;
    logic [7:0]  r_col;
    logic [6:0]  r_row;
    logic        w_take;
    logic [15:0] w_cell;

    assign w_take = bus.in_valid && r_ready;
    assign w_cell = r_base + {8'd0, r_col};

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CLEAR;
            r_addr   <= '0;
            r_data   <= '0;
            r_base   <= '0;
            r_we     <= 1'b0;
            r_oe     <= 1'b0;
            r_copy   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_scroll <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
        end else begin
            case (r_state)
                // r_we low here only on the first cycle after reset
                CLEAR: begin
                    r_data <= BLANK;
                    if (!r_we) begin
                        r_we   <= 1'b1;
                        r_addr <= '0;
                    end else if (r_addr == LAST_CELL) begin
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else
                        r_addr <= r_addr + 16'd1;
                end
                IDLE: if (w_take) begin
                    case (bus.in_char)
                        8'h0D: r_col <= '0;
                        8'h0A: begin
                            r_col <= '0;
                            if (r_row != LAST_ROW) begin
                                r_row  <= r_row + 7'd1;
                                r_base <= r_base + W_COL;
                            end else begin
                                r_oe    <= 1'b1;
                                r_addr  <= W_COL;
                                r_ready <= 1'b0;
                                r_busy  <= 1'b1;
                                r_state <= SCROLL_RD;
                            end
                        end
                        8'h08: if (r_col != 8'd0) begin
                            r_col    <= r_col - 8'd1;
                            r_addr   <= w_cell - 16'd1;
                            r_data   <= BLANK;
                            r_we     <= 1'b1;
                            r_scroll <= 1'b0;
                            r_ready  <= 1'b0;
                            r_busy   <= 1'b1;
                            r_state  <= PUT;
                        end
                        8'h0C: begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_base  <= '0;
                            r_addr  <= '0;
                            r_data  <= BLANK;
                            r_we    <= 1'b1;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= CLEAR;
                        end
                        default: begin
                            r_addr   <= w_cell;
                            r_data   <= {bus.in_attr, bus.in_char};
                            r_we     <= 1'b1;
                            r_ready  <= 1'b0;
                            r_busy   <= 1'b1;
                            r_state  <= PUT;
                            r_scroll <= (r_col == LAST_COL) && (r_row == LAST_ROW);
                            r_col    <= (r_col == LAST_COL) ? 8'd0 : r_col + 8'd1;
                            if (r_col == LAST_COL && r_row != LAST_ROW) begin
                                r_row  <= r_row + 7'd1;
                                r_base <= r_base + W_COL;
                            end
                        end
                    endcase
                end
                PUT: begin
                    r_we <= 1'b0;
                    if (r_scroll) begin
                        r_oe    <= 1'b1;
                        r_addr  <= W_COL;
                        r_state <= SCROLL_RD;
                    end else begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                // write data bypasses straight from the RAM read register while r_copy is set
                SCROLL_RD: begin
                    r_oe    <= 1'b0;
                    r_we    <= 1'b1;
                    r_copy  <= 1'b1;
                    r_addr  <= r_addr - W_COL;
                    r_state <= SCROLL_WR;
                end
                SCROLL_WR: begin
                    r_copy <= 1'b0;
                    if (r_addr == LAST_BASE - 16'd1) begin
                        r_addr  <= LAST_BASE;
                        r_data  <= BLANK;
                        r_state <= SCROLL_BLANK;
                    end else begin
                        r_we    <= 1'b0;
                        r_oe    <= 1'b1;
                        r_addr  <= r_addr + W_COL + 16'd1;
                        r_state <= SCROLL_RD;
                    end
                end
                SCROLL_BLANK: if (r_addr == LAST_CELL) begin
                    r_we    <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else
                    r_addr <= r_addr + 16'd1;
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign bus.in_ready    = r_ready;
    assign bus.busy        = r_busy;
    assign bus.ram_addr    = r_addr;
    assign bus.ram_we      = r_we;
    assign bus.ram_oe      = r_oe;
    assign bus.ram_dataOut = r_copy ? bus.ram_dataIn : r_data;
    assign bus.cursor_col  = r_col;
    assign bus.cursor_row  = r_row;
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: randomized scoreboard bench with a screen-level reference model.
module tb_text_console_writer;
    localparam int NC = 4;
    localparam int NR = 3;
    localparam logic [15:0] BLANK = 16'h0720;

    typedef struct packed {logic rd; logic [15:0] addr; logic [15:0] data;} op_t;

    logic clk, rst_n;
    text_console_writer_if bus();

    text_console_writer #(.N_COL(NC), .N_ROW(NR), .CLEAR_ATTR(8'h07)) dut (
        .cpu_clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // RAM model: synchronous write, registered read data
    logic [15:0] mem [16];
    logic [15:0] rd_q;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr[3:0]] <= bus.ram_dataOut;
        if (bus.ram_oe) rd_q <= mem[bus.ram_addr[3:0]];
    end
    assign bus.ram_dataIn = rd_q;

    int n_cmp = 0, n_err = 0;
    op_t expq[$];
    logic [15:0] scr [NC*NR];
    int cc, cr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (rst_n && (bus.ram_we || bus.ram_oe)) begin : mon
        op_t e;
        chk("we_oe_excl", {31'd0, bus.ram_we & bus.ram_oe}, 0);
        if (expq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_op: addr %0h we %0b oe %0b, none expected", bus.ram_addr, bus.ram_we, bus.ram_oe);
        end else begin
            e = expq.pop_front();
            chk("op_kind_rd", {31'd0, bus.ram_oe}, {31'd0, e.rd});
            chk("op_addr", {16'd0, bus.ram_addr}, {16'd0, e.addr});
            if (!e.rd) chk("op_data", {16'd0, bus.ram_dataOut}, {16'd0, e.data});
        end
    end

    function automatic void push_w(input int ad, input logic [15:0] d);
        expq.push_back(op_t'{rd: 1'b0, addr: 16'(ad), data: d});
    endfunction

    function automatic void push_clear();
        for (int i = 0; i < NC*NR; i++) begin
            push_w(i, BLANK);
            scr[i] = BLANK;
        end
        cc = 0;
        cr = 0;
    endfunction

    function automatic void do_scroll();
        for (int a = 0; a < (NR-1)*NC; a++) begin
            expq.push_back(op_t'{rd: 1'b1, addr: 16'(a + NC), data: 16'd0});
            push_w(a, scr[a + NC]);
            scr[a] = scr[a + NC];
        end
        for (int a = (NR-1)*NC; a < NR*NC; a++) begin
            push_w(a, BLANK);
            scr[a] = BLANK;
        end
    endfunction

    // lat: cycles from acceptance until in_ready is high again
    function automatic void model_byte(input logic [7:0] c, input logic [7:0] a, output int lat, output bit wr);
        wr = 0;
        lat = 1;
        if (c == 8'h0D) cc = 0;
        else if (c == 8'h0A) begin
            cc = 0;
            if (cr < NR-1) cr++;
            else begin
                do_scroll();
                lat = 1 + 2*(NR-1)*NC + NC;
            end
        end else if (c == 8'h08) begin
            if (cc > 0) begin
                cc--;
                push_w(cr*NC + cc, BLANK);
                scr[cr*NC + cc] = BLANK;
                wr = 1;
                lat = 2;
            end
        end else if (c == 8'h0C) begin
            push_clear();
            wr = 1;
            lat = 1 + NC*NR;
        end else begin
            push_w(cr*NC + cc, {a, c});
            scr[cr*NC + cc] = {a, c};
            wr = 1;
            lat = 2;
            cc++;
            if (cc == NC) begin
                cc = 0;
                if (cr < NR-1) cr++;
                else begin
                    do_scroll();
                    lat = 2 + 2*(NR-1)*NC + NC;
                end
            end
        end
    endfunction

    task automatic send(input logic [7:0] c, input logic [7:0] a, input bit wait_done, output int waited);
        int lat, el;
        bit wr;
        bus.in_valid = 1;
        bus.in_char = c;
        bus.in_attr = a;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("accept_timeout", {31'd0, bus.in_ready}, 1);
        model_byte(c, a, lat, wr);
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        bus.in_char = 8'($urandom);
        bus.in_attr = 8'($urandom);
        chk("we_after_accept", {31'd0, bus.ram_we}, {31'd0, wr});
        if (lat <= 2) begin
            chk("col_after_accept", {24'd0, bus.cursor_col}, cc);
            chk("row_after_accept", {25'd0, bus.cursor_row}, cr);
        end
        if (wait_done) begin
            el = 1;
            while (!bus.in_ready && el < 100) begin
                @(posedge clk);
                #1;
                el++;
            end
            chk("ready_latency", el, lat);
            chk("col_done", {24'd0, bus.cursor_col}, cc);
            chk("row_done", {25'd0, bus.cursor_row}, cr);
        end
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (!bus.ram_we && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clear_cycles", n, NC*NR);
        chk("clear_busy", {31'd0, bus.busy}, 0);
        chk("clear_col", {24'd0, bus.cursor_col}, 0);
        chk("clear_row", {25'd0, bus.cursor_row}, 0);
    endtask

    initial begin
        int w;
        logic [7:0] ch;
        rst_n = 0;
        bus.in_valid = 0;
        bus.in_char = 0;
        bus.in_attr = 0;
        cc = 0;
        cr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 1);
        chk("rst_we", {31'd0, bus.ram_we}, 0);
        chk("rst_oe", {31'd0, bus.ram_oe}, 0);
        chk("rst_addr", {16'd0, bus.ram_addr}, 0);
        chk("rst_data", {16'd0, bus.ram_dataOut}, 0);
        chk("rst_col", {24'd0, bus.cursor_col}, 0);
        chk("rst_row", {25'd0, bus.cursor_row}, 0);
        push_clear();
        rst_n = 1;
        wait_clear();

        send(8'h41, 8'h1F, 1, w);
        chk("home_col", {24'd0, bus.cursor_col}, 1);

        send(8'h0D, 8'h00, 1, w);
        send(8'h0A, 8'h00, 1, w);
        for (int i = 0; i < 4; i++) send(8'h61 + 8'(i), 8'($urandom), 1, w);
        chk("wrap_col", {24'd0, bus.cursor_col}, 0);
        chk("wrap_row", {25'd0, bus.cursor_row}, 2);

        send(8'h08, 8'h00, 1, w);
        send(8'h78, 8'h2E, 1, w);
        send(8'h79, 8'h3C, 1, w);
        send(8'h08, 8'h00, 1, w);
        chk("bs_col", {24'd0, bus.cursor_col}, 1);
        chk("bs_row", {25'd0, bus.cursor_row}, 2);

        send(8'h0A, 8'h00, 1, w);
        chk("scroll_col", {24'd0, bus.cursor_col}, 0);
        chk("scroll_row", {25'd0, bus.cursor_row}, 2);

        // form feed held on the input while a scroll is still running
        send(8'h0A, 8'h00, 0, w);
        send(8'h0C, 8'h00, 1, w);
        chk("hold_wait", w, 2*(NR-1)*NC + NC);

        // reset in the middle of a scroll
        send(8'h0A, 8'h00, 1, w);
        send(8'h0A, 8'h00, 1, w);
        send(8'h51, 8'h4A, 1, w);
        send(8'h0A, 8'h00, 0, w);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 0;
        #1;
        chk("abort_we", {31'd0, bus.ram_we}, 0);
        chk("abort_oe", {31'd0, bus.ram_oe}, 0);
        chk("abort_addr", {16'd0, bus.ram_addr}, 0);
        expq.delete();
        push_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
        wait_clear();

        for (int k = 0; k < 200; k++) begin
            int r;
            r = int'($urandom_range(0, 39));
            ch = (r == 0) ? 8'h0D : (r < 4) ? 8'h0A : (r < 7) ? 8'h08 : (r == 7) ? 8'h0C : 8'($urandom_range(32, 126));
            send(ch, 8'($urandom), 1, w);
            repeat (int'($urandom_range(0, 2))) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);
        for (int i = 0; i < NC*NR; i++) chk("screen_cell", {16'd0, mem[i]}, {16'd0, scr[i]});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
